// File: rtl/register_file_pkg.sv
// register_file_pkg: shared default sizes for register_file and its bench
package register_file_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;
  localparam int ADDR_W_DEF = 3;
endpackage

// File: rtl/register_file_word_register.sv
// word_register: WIDTH-bit write-enabled flop word with sync active-low clear (clk, rst_n, w, d -> q)
module word_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (!rst_n) q <= '0;
    else if (w) q <= d;
endmodule

// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH regs, reg 0 hardwired zero, 1 write port (w, waddr, d), 2 comb read ports (raddr_a/b -> q_a/b), sync active-low rst_n
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  d,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  q_a,
  output logic [WIDTH-1:0]  q_b
);
  logic [WIDTH-1:0] regs [DEPTH];
  assign regs[0] = '0;
  for (genvar g = 1; g < DEPTH; g++) begin : g_reg
    logic we;
    assign we = w && waddr == ADDR_W'(g);
    word_register #(.WIDTH(WIDTH)) u_word (
      .clk  (clk),
      .rst_n(rst_n),
      .w    (we),
      .d    (d),
      .q    (regs[g])
    );
  end
  assign q_a = regs[raddr_a];
  assign q_b = regs[raddr_b];
endmodule
